// File: rtl/btn_debounce4.sv
// Four-channel push-button conditioner: two-flop synchronizer, per-channel
// stability counter, debounced level and one-cycle rising-edge strobe.
module btn_debounce4 #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  // Counter value at which a persisting mismatch is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             level_d;
      logic             pulse_q;
      logic             pulse_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             mismatch;

      assign mismatch = sync2_q ^ level_q;

      // Any cycle without a mismatch clears the counter, so a bounce back to
      // the current level aborts the pending change.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (mismatch) begin
          if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          cnt_q   <= '0;
          level_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          pulse_q <= pulse_d;
        end
      end

      assign btn_level[gi] = level_q;
      assign btn_pulse[gi] = pulse_q;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce4.sv
// Bench for btn_debounce4: directed scenarios with literal expectations plus
// randomized bouncing stimulus checked every cycle against a window model.
module tb_btn_debounce4;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  int errors = 0;
  int checks = 0;
  int pc[N] = '{default: 0};

  always #5 clk = ~clk;

  btn_debounce4 #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  // Reference: the raw value sampled at edge j reaches the debouncer's input
  // two edges later. A channel accepts at edge n when the last DB debouncer
  // inputs all differ from its level and at least DB edges have elapsed since
  // its last acceptance (or since reset release).
  logic [N-1:0] hist[$];
  int           ecount = 0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pulse = '0;
  int           t_acc[N] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    bit   ok;
    int   j;
    logic s;
    if (!rst_n) begin
      hist.delete();
      ecount  = 0;
      m_level = '0;
      m_pulse = '0;
      for (int i = 0; i < N; i++) t_acc[i] = 0;
    end else begin
      ecount++;
      hist.push_back(btn_raw);
      for (int i = 0; i < N; i++) begin
        ok = (ecount - t_acc[i] >= DB);
        for (int w = 0; w < DB; w++) begin
          j = ecount - w;
          s = (j >= 3) ? hist[j-3][i] : 1'b0;
          if (s == m_level[i]) ok = 1'b0;
        end
        m_pulse[i] = 1'b0;
        if (ok) begin
          m_level[i] = ~m_level[i];
          m_pulse[i] = m_level[i];
          t_acc[i]   = ecount;
        end
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("level_vs_model", btn_level, m_level);
      check("pulse_vs_model", btn_pulse, m_pulse);
      for (int i = 0; i < N; i++) if (btn_pulse[i]) pc[i]++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("reset_level", btn_level, 4'b0000);
    check("reset_pulse", btn_pulse, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int p0;
  int div;

  initial begin
    // Reset state and clean press on channel 0.
    #23;
    check("rst_level", btn_level, 4'b0000);
    check("rst_pulse", btn_pulse, 4'b0000);
    @(negedge clk);
    rst_n   = 1'b1;
    btn_raw = 4'b0001;
    step(5);
    check("t1_level_early", btn_level, 4'b0000);
    step(1);
    check("t1_level", btn_level, 4'b0001);
    check("t1_pulse", btn_pulse, 4'b0001);
    check("t1_model_pulse", m_pulse, 4'b0001);
    step(1);
    check("t1_pulse_off", btn_pulse, 4'b0000);
    step(10);
    check_int("t1_pulse_count", pc[0], 1);

    // Bounce on channel 1.
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    step(4);
    check("t2_level_early", btn_level, 4'b0001);
    step(1);
    check("t2_level", btn_level, 4'b0011);
    check("t2_pulse", btn_pulse, 4'b0010);
    step(6);
    check_int("t2_pulse_count", pc[1], 1);

    // Short glitch on channel 2.
    btn_raw[2] = 1'b1; step(3);
    btn_raw[2] = 1'b0; step(10);
    check("t3_level", btn_level, 4'b0011);
    check_int("t3_pulse_count", pc[2], 0);

    // Press then release on channel 3.
    btn_raw[3] = 1'b1; step(8);
    check("t4_level_high", btn_level, 4'b1011);
    btn_raw[3] = 1'b0; step(1);
    step(4);
    check("t4_level_early", btn_level, 4'b1011);
    step(1);
    check("t4_level_low", btn_level, 4'b0011);
    check("t4_pulse", btn_pulse, 4'b0000);
    step(5);
    check_int("t4_pulse_count", pc[3], 1);

    // Simultaneous press on channels 1 and 3.
    btn_raw = 4'b0000; step(8);
    check("t5_idle", btn_level, 4'b0000);
    btn_raw = 4'b1010; step(5);
    check("t5_pulse_early", btn_pulse, 4'b0000);
    step(1);
    check("t5_pulse", btn_pulse, 4'b1010);
    step(1);
    check("t5_pulse_off", btn_pulse, 4'b0000);
    check("t5_level", btn_level, 4'b1010);

    // Reset in the middle of a pending press.
    btn_raw = 4'b0000; step(8);
    btn_raw = 4'b0001; step(3);
    p0 = pc[0];
    async_reset_pulse();
    step(5);
    check("t6_pulse_early", btn_pulse, 4'b0000);
    step(1);
    check("t6_pulse", btn_pulse, 4'b0001);
    check("t6_level", btn_level, 4'b0001);
    step(10);
    check_int("t6_pulse_count", pc[0] - p0, 1);

    // Randomized bouncing on all channels with occasional resets.
    div = 4;
    for (int it = 0; it < 3000; it++) begin
      if (it % 200 == 0) div = int'($urandom_range(2, 12));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, div - 1) == 0) btn_raw[i] = ~btn_raw[i];
      step(1);
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_debounce4.md
# btn_debounce4

Four-channel push-button conditioner that sits directly upstream of the digit-edit stage. That stage increments or decrements one hex digit of the 16-bit working number on each rising edge of its `btn[i]` input.
- Each raw, bouncing board button passes through a two-flop synchronizer and a per-channel stability counter.
- The block produces a clean debounced level `btn_level` and a single-cycle rising-edge strobe `btn_pulse`.
- `btn_level[3:0]` drives the digit-edit stage's `btn[3:0]`, so each physical press yields exactly one digit step.

## Interface
- `N_BTN`, 4: number of independent channels.
- `DB_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2 to 2^`CNT_W`-1.
- `CNT_W`, 20: stability counter width.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  `N_BTN`  raw, asynchronous button inputs, active-high.
- `btn_level`  out  `N_BTN`  debounced button level, registered.
- `btn_pulse`  out  `N_BTN`  one-cycle strobe on each debounced 0→1 transition, registered.

## Operation
- Per channel i, all channels fully independent:
  - `sync1[i]` <= `btn_raw[i]`; `sync2[i]` <= `sync1[i]`. Only `sync2` is used downstream.
  - Mismatch `m[i]` = `sync2[i]` != `btn_level[i]`.
  - If `m[i]`=0: `cnt[i]` <= 0.
  - If `m[i]`=1 and `cnt[i]` < `DB_CYCLES`-1: `cnt[i]` <= `cnt[i]`+1.
  - If `m[i]`=1 and `cnt[i]` == `DB_CYCLES`-1:
    - `btn_level[i]` <= `sync2[i]`; `cnt[i]` <= 0.
    - `btn_pulse[i]` <= 1 if the new level is 1; otherwise `btn_pulse[i]` <= 0.
  - In every other cycle, `btn_pulse[i]` <= 0.
- Per-channel states:
  - STABLE: `cnt`=0, `m`=0.
  - PENDING: `cnt`>0, or `m`=1.
  - A PENDING→STABLE transition happens either by acceptance (level flips) or by abort (the input returns to the current level and the counter clears).
- Counter arithmetic is unsigned `CNT_W` bits. The counter never exceeds `DB_CYCLES`-1, so there is no wrap-around.
- A release (1→0 level transition) updates `btn_level` and never asserts `btn_pulse`.

## Timing
- Reset, asynchronous on `rst_n`=0: `sync1`, `sync2`, `cnt`, `btn_level` and `btn_pulse` all clear to 0 immediately, independent of `clk`.
- Reset release: the first state update happens on the first `clk` rising edge with `rst_n`=1.
- A button held at 1 through reset release is treated as a new press: `btn_level` rises and `btn_pulse` fires after the full latency.
- Latency: `btn_raw[i]` sampled changed at edge k and held stable ⇒ `btn_level[i]` (and `btn_pulse[i]` for a press) change at edge k+1+`DB_CYCLES`.
- `btn_pulse[i]` is high for exactly one cycle per accepted press.
- Any return of `sync2` to the current level before acceptance aborts the pending change; the counter restarts from 0 on the next mismatch.
- Glitches shorter than `DB_CYCLES` cycles in `sync2` never change outputs.
- Simultaneous events on several channels are processed in the same cycle with no interaction. Several `btn_pulse` bits may be high together.
- Reset asserted mid-count discards the pending change; no pulse is emitted.

## Test plan
Directed scenarios use `DB_CYCLES`=4 and `CNT_W`=3.
1. Clean press: `rst_n` released; `btn_raw`=4'b0001 sampled at edge 0 and held.
   - Required: `btn_level`=4'b0001 and `btn_pulse`=4'b0001 after edge 5.
   - Required: `btn_pulse`=0 after edge 6.
   - Required: no further pulses while the button is held.
2. Bounce: `btn_raw[1]` toggles 1,0,1,1,0,1 (one cycle each), then holds 1.
   - Required: no output change during the bounce.
   - Required: exactly one `btn_pulse[1]`, four cycles plus synchronizer delay after the final 0→1.
3. Glitch: `btn_raw[2]`=1 for 3 cycles, then 0.
   - Required: `btn_level[2]` and `btn_pulse[2]` remain 0 throughout.
4. Release: channel 3 debounced high, then `btn_raw[3]`=0 held.
   - Required: `btn_level[3]` falls at edge k+5.
   - Required: `btn_pulse[3]` stays 0.
5. Simultaneous: `btn_raw`=4'b1010 at the same edge.
   - Required: `btn_pulse`=4'b1010 for one cycle, at the same edge for both channels.
6. Reset mid-count: press channel 0; assert `rst_n`=0 two cycles later, asynchronously between edges.
   - Required: all outputs are 0 immediately.
   - Required: after release with `btn_raw`=4'b0001 still held, `btn_pulse[0]` fires exactly once, 5 edges after release.
